// File: rtl/uart_debug_arbiter_pkg.sv
// Shared types and width helpers for the debug-UART arbiter.
package uart_debug_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  localparam logic [7:0] TAG_BASE = 8'hA0;

  function automatic int data_w(input int data_bytes);
    return data_bytes * 8;
  endfunction

  function automatic int frame_w(input int data_bytes);
    return (data_bytes + 1) * 8;
  endfunction

endpackage

// File: rtl/uart_debug_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or above last_grant+1, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [3:0]   last_grant_i,
  output logic [N-1:0] grant_o,
  output logic [3:0]   idx_o,
  output logic         any_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last_grant_i) + i) % N);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = 4'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_debug_arbiter.sv
// Shares the debugger transmit path between NUM_CH requesters: round-robin grant,
// tag-prefixed frame, then waits for the debugger's busy pulse before granting again.
module uart_debug_arbiter
  import uart_debug_arbiter_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_BYTES   = 2,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic [NUM_CH-1:0]              i_chan_en,
  input  logic [NUM_CH-1:0]              i_req_valid,
  input  logic [NUM_CH*DATA_BYTES*8-1:0] i_req_data,
  output logic [NUM_CH-1:0]              o_req_ready,
  input  logic                           i_dbg_busy,
  output logic                           o_dbg_valid,
  output logic [(DATA_BYTES+1)*8-1:0]    o_dbg_data,
  output logic [3:0]                     o_grant_id,
  output logic                           o_timeout
);

  localparam int W  = data_w(DATA_BYTES);
  localparam int FW = frame_w(DATA_BYTES);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      last_q, last_d;
  logic            run_q;
  logic            valid_q, valid_d;
  logic [FW-1:0]   data_q, data_d;
  logic [3:0]      gid_q, gid_d;
  logic            to_q, to_d;

  logic [NUM_CH-1:0] win_oh;
  logic [3:0]        win_idx;
  logic              win_any;
  logic [W-1:0]      win_word;

  rr_arbiter #(.N(NUM_CH)) u_rr (
    .req_i        (i_req_valid & i_chan_en),
    .last_grant_i (last_q),
    .grant_o      (win_oh),
    .idx_o        (win_idx),
    .any_o        (win_any)
  );

  assign win_word = i_req_data[win_idx*W +: W];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    gid_d       = gid_q;
    to_d        = to_q;
    o_req_ready = '0;
    unique case (state_q)
      IDLE: begin
        // Grant only while the debugger is idle; busy falling is never a grant cycle.
        if (run_q && win_any && !i_dbg_busy) begin
          o_req_ready = win_oh;
          data_d      = {TAG_BASE | {4'h0, win_idx}, win_word};
          valid_d     = 1'b1;
          gid_d       = win_idx;
          last_d      = win_idx;
          cnt_d       = '0;
          state_d     = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (i_dbg_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!i_dbg_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 4'(NUM_CH - 1);
      run_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      gid_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      run_q   <= 1'b1;
      valid_q <= valid_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      to_q    <= to_d;
    end
  end

  assign o_dbg_valid = valid_q;
  assign o_dbg_data  = data_q;
  assign o_grant_id  = gid_q;
  assign o_timeout   = to_q;

endmodule

// File: tb/tb_uart_debug_arbiter.sv
// Randomized bench for uart_debug_arbiter: emulated debugger busy, requester agents,
// and an event-level model of the arbitration rules compared every cycle.
module tb_uart_debug_arbiter;

  localparam int NUM_CH       = 4;
  localparam int DATA_BYTES   = 2;
  localparam int BUSY_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  chan_en;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        busy;
  logic        dbg_valid;
  logic [23:0] dbg_data;
  logic [3:0]  grant_id;
  logic        timeout;

  always #5 clk = ~clk;

  uart_debug_arbiter #(
    .NUM_CH(NUM_CH), .DATA_BYTES(DATA_BYTES), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_chan_en   (chan_en),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .i_dbg_busy  (busy),
    .o_dbg_valid (dbg_valid),
    .o_dbg_data  (dbg_data),
    .o_grant_id  (grant_id),
    .o_timeout   (timeout)
  );

  int errors = 0;
  int checks = 0;

  // Model: phase 0 = free to grant, 1 = frame issued awaiting busy, 2 = awaiting busy release.
  int          m_phase, m_age, m_next;
  bit          m_run, m_valid, m_to;
  logic [23:0] m_data;
  logic [3:0]  m_gid;

  logic [3:0]  s_ready;
  bit          s_valid, s_to;
  logic [23:0] s_data;
  logic [3:0]  s_gid;
  int          gq[$];
  logic [3:0]  prev_v, prev_r;
  bit          prev_rst;

  int          busy_mode;   // 0 emulated debugger, 1 tied low, 2 forced high
  int          busy_min, busy_max, busy_left, drop_pct, arrive_pct;
  bit          cont;
  logic [15:0] word[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] e, input int start);
    for (int i = 0; i < NUM_CH; i++)
      if (e[(start + i) % NUM_CH]) return (start + i) % NUM_CH;
    return -1;
  endfunction

  task automatic pack();
    for (int k = 0; k < NUM_CH; k++) req_data[k*16 +: 16] = word[k];
  endtask

  task automatic model_check();
    logic [3:0] exp_r;
    int w;
    exp_r = '0;
    w     = -1;
    if (!rst_n) begin
      m_phase = 0; m_next = 0; m_run = 0; m_valid = 0; m_to = 0; m_data = '0; m_gid = '0;
    end else if (m_run && m_phase == 0 && !busy && (req_valid & chan_en) != 0) begin
      w     = pick(req_valid & chan_en, m_next);
      exp_r = 4'(1 << w);
    end
    chk("req_ready", 32'(req_ready), 32'(exp_r));
    chk("dbg_valid", 32'(dbg_valid), 32'(m_valid));
    chk("dbg_data",  32'(dbg_data),  32'(m_data));
    chk("grant_id",  32'(grant_id),  32'(m_gid));
    chk("timeout",   32'(timeout),   32'(m_to));
    if (rst_n && prev_rst)
      chk("protocol_valid_hold", 32'(prev_v & ~prev_r & ~req_valid), 32'd0);
    prev_v = req_valid; prev_r = req_ready; prev_rst = rst_n;
    s_ready = req_ready; s_valid = dbg_valid; s_data = dbg_data; s_gid = grant_id; s_to = timeout;
    if (w >= 0) gq.push_back(w);
    if (rst_n) begin
      m_valid = (w >= 0);
      if (w >= 0) begin
        m_data  = {8'hA0 | 8'(w), req_data[w*16 +: 16]};
        m_gid   = 4'(w);
        m_next  = (w + 1) % NUM_CH;
        m_phase = 1;
        m_age   = 0;
      end else if (m_phase == 1) begin
        if (busy) m_phase = 2;
        else if (m_age == BUSY_TIMEOUT - 1) begin m_to = 1; m_phase = 0; end
        else m_age++;
      end else if (m_phase == 2 && !busy) begin
        m_phase = 0;
      end
      m_run = 1;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NUM_CH; k++) begin
      if (s_ready[k]) begin
        if (cont) word[k] = 16'($urandom);
        else req_valid[k] = 1'b0;
      end else if (!req_valid[k] && int'($urandom_range(99)) < arrive_pct) begin
        req_valid[k] = 1'b1;
        word[k]      = 16'($urandom);
      end
    end
    pack();
    case (busy_mode)
      1: busy = 1'b0;
      2: busy = 1'b1;
      default: begin
        if (s_valid) begin
          if (int'($urandom_range(99)) >= drop_pct) begin
            busy      = 1'b1;
            busy_left = int'($urandom_range(busy_max, busy_min));
          end
        end else if (busy) begin
          if (busy_left <= 1) busy = 1'b0;
          else busy_left--;
        end
      end
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; req_valid = '0; busy = 1'b0; busy_left = 0; s_ready = '0; s_valid = 1'b0;
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gq.delete();
  endtask

  task automatic run_until_grants(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (gq.size() < n && c < budget) begin step(); c++; end
    checks++;
    if (gq.size() < n) begin
      errors++;
      $display("FAIL %s: %0d grants seen, %0d required", name, gq.size(), n);
    end
  endtask

  initial begin
    logic [3:0] seen;
    int c;
    rst_n = 1'b0; chan_en = 4'hF; req_valid = '0; req_data = '0; busy = 1'b0;
    busy_mode = 0; busy_min = 1; busy_max = 4; busy_left = 0; drop_pct = 0;
    arrive_pct = 0; cont = 0; prev_v = '0; prev_r = '0; prev_rst = 0;
    s_ready = '0; s_valid = 0;
    for (int k = 0; k < NUM_CH; k++) word[k] = '0;

    // 1: single request on channel 2
    apply_reset();
    busy_min = 20; busy_max = 20;
    step(); step();
    req_valid = 4'b0100; word[2] = 16'hBEEF; pack();
    run_until_grants(1, 10, "t1_grant");
    chk("t1_ready", 32'(s_ready), 32'h4);
    step();
    chk("t1_valid", 32'(s_valid), 32'h1);
    chk("t1_data",  32'(s_data),  32'hA2BEEF);
    chk("t1_gid",   32'(s_gid),   32'h2);
    req_valid[0] = 1'b1; word[0] = 16'h1234; pack();
    repeat (15) step();
    chk("t1_no_grant_while_busy", 32'(gq.size()), 32'd1);

    // 2: all channels continuously valid
    apply_reset();
    cont = 1; arrive_pct = 100; busy_min = 3; busy_max = 5;
    run_until_grants(5, 200, "t2_grants");
    for (int i = 0; i < 5 && i < gq.size(); i++)
      chk("t2_order", 32'(gq[i]), 32'(i % 4));

    // 3: only channels 1 and 3 enabled
    apply_reset();
    chan_en = 4'b1010; seen = '0;
    for (int i = 0; i < 80; i++) begin step(); seen |= s_ready; end
    chk("t3_disabled_never_ready", 32'(seen & 4'b0101), 32'd0);
    run_until_grants(4, 50, "t3_grants");
    for (int i = 0; i < 4 && i < gq.size(); i++)
      chk("t3_alternate", 32'(gq[i]), (i % 2) ? 32'd3 : 32'd1);

    // 4: busy never rises -> timeout
    apply_reset();
    chan_en = 4'hF; cont = 0; arrive_pct = 0; busy_mode = 1;
    req_valid = 4'b0010; word[1] = 16'($urandom); pack();
    run_until_grants(1, 10, "t4_grant");
    step();
    chk("t4_valid", 32'(s_valid), 32'h1);
    repeat (63) step();
    chk("t4_timeout_not_yet", 32'(s_to), 32'h0);
    step();
    chk("t4_timeout_rise", 32'(s_to), 32'h1);
    busy_mode = 0; busy_min = 2; busy_max = 2;
    req_valid = 4'b0101; word[0] = 16'h0A0A; word[2] = 16'h0C0C; pack();
    run_until_grants(2, 10, "t4_next_grant");
    if (gq.size() >= 2) chk("t4_rr_next", 32'(gq[1]), 32'd2);

    // 5: reset while waiting for busy to fall
    apply_reset();
    cont = 1; arrive_pct = 100; busy_min = 8; busy_max = 8;
    run_until_grants(2, 100, "t5_grants");
    c = 0;
    while (!busy && c < 20) begin step(); c++; end
    chk("t5_busy_seen", 32'(busy), 32'h1);
    rst_n = 1'b0; busy = 1'b0; busy_left = 0; chan_en = 4'b1101;
    @(negedge clk);
    model_check();
    chk("t5_async_valid", 32'(s_valid), 32'h0);
    chk("t5_async_gid",   32'(s_gid),   32'h0);
    chk("t5_async_to",    32'(s_to),    32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_ready = '0; s_valid = 1'b0;
    step();
    chk("t5_no_ready_first_cycle", 32'(s_ready), 32'h0);
    step();
    chk("t5_lowest_eligible", 32'(s_ready), 32'h1);

    // 6: busy already high when the request arrives
    apply_reset();
    chan_en = 4'hF; cont = 0; arrive_pct = 0; busy_mode = 2;
    step(); step();
    req_valid = 4'b1000; word[3] = 16'h5A5A; pack();
    seen = '0;
    repeat (5) begin step(); seen |= s_ready; end
    chk("t6_no_ready_while_busy", 32'(seen), 32'h0);
    busy_mode = 0; busy = 1'b0; busy_left = 0; busy_min = 2; busy_max = 6;
    step();
    chk("t6_ready_when_idle", 32'(s_ready), 32'h8);

    // Randomized traffic with occasional dropped frames and enable changes
    apply_reset();
    busy_min = 1; busy_max = 8; drop_pct = 10; arrive_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) chan_en = 4'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_debug_arbiter.md
Name: uart_debug_arbiter

Overview:
Shares one uart_debugger transmit path between NUM_CH requesters inside the breakout gateware. Each requester offers a DATA_BYTES-wide word through a valid/ready handshake. The block grants requesters round-robin, prepends a channel tag byte, and issues one frame to the debugger. It then waits out the debugger's send-plus-dead-time before granting again.

Parameters:
NUM_CH, 4, number of requesters (2..16)
DATA_BYTES, 2, payload bytes per requester word
BUSY_TIMEOUT, 64, clocks to wait for i_dbg_busy to rise after issue before abandoning the frame

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous, active-low reset
i_chan_en  in  NUM_CH  per-channel enable mask; disabled channels are never granted
i_req_valid  in  NUM_CH  per-channel word valid; held until ready
i_req_data  in  NUM_CH*DATA_BYTES*8  packed words; channel k occupies bits [k*W +: W], where W = DATA_BYTES*8
o_req_ready  out  NUM_CH  one-hot grant/accept strobe
i_dbg_busy  in  1  high whenever the downstream debugger is not idle
o_dbg_valid  out  1  single-cycle frame strobe to the debugger
o_dbg_data  out  (DATA_BYTES+1)*8  frame = {tag, payload}, tag in the MSB byte
o_grant_id  out  4  channel of the most recent grant
o_timeout  out  1  sticky flag: an issued frame was never acknowledged by busy

Behaviour:
- Reset (i_reset_n low, async):
  - state=IDLE, rr pointer=0 (channel 0 has top priority first).
  - o_dbg_valid=0, o_dbg_data=0, o_grant_id=0, o_timeout=0, o_req_ready=0.
  - A run flag clears on reset and sets on the first clock after release. o_req_ready is gated by run, so it is 0 for that first cycle.
- Eligible set E = i_req_valid & i_chan_en.
- Grant selection: first set bit of E scanning upward from (last_grant+1) mod NUM_CH, wrapping.
- IDLE:
  - If run, E != 0 and i_dbg_busy == 0, then o_req_ready = one-hot(winner) combinationally this cycle (cycle T). No other ready bit is high.
  - At the end of T:
    - capture the winner's word;
    - o_dbg_data <= {8'hA0 | winner[3:0], word};
    - o_dbg_valid <= 1, o_grant_id <= winner, last_grant <= winner;
    - go to WAIT_BUSY.
  - If i_dbg_busy is high in IDLE, no grant is made.
- WAIT_BUSY:
  - o_dbg_valid is high in T+1 only, cleared after one cycle. o_dbg_data holds until the next grant.
  - A counter starts at 0 in T+1.
  - If i_dbg_busy == 1, go to WAIT_DONE.
  - Else if the counter reaches BUSY_TIMEOUT-1, set o_timeout=1 and go to IDLE.
- WAIT_DONE: when i_dbg_busy == 0, go to IDLE. A new grant is possible the following cycle.
- Latency: handshake cycle to o_dbg_valid = 1 clock.
- Back-to-back: a grant is never made in the same cycle busy falls.
- Requester drops valid before ready: not granted. Requesters must not do this (protocol rule); the bench asserts it.
- i_chan_en changes apply immediately to arbitration. They do not affect a frame already captured.
- Single eligible channel: granted repeatedly, with the rr pointer wrapping to itself.
- o_timeout is cleared only by reset.
- Reset mid-frame:
  - outputs return to reset values asynchronously;
  - the in-flight frame is abandoned;
  - the requester whose word was accepted is not re-served.

Decomposition:
- Shared package/header: state encoding (IDLE=2'd0, WAIT_BUSY=2'd1, WAIT_DONE=2'd2), TAG_BASE=8'hA0, width helpers W and FRAME_W.
- One natural sub-module, rr_arbiter: combinational round-robin pick.
  - Inputs: request vector, last_grant.
  - Outputs: one-hot grant, index, any.
  - Reusable elsewhere in the gateware.

Test Plan:
1. Single request, default params: ch2 valid with 16'hBEEF, busy modelled as high 1 cycle after the valid pulse for 20 cycles.
   - o_req_ready=4'b0100 for 1 cycle.
   - Next cycle o_dbg_valid=1, o_dbg_data=24'hA2BEEF.
   - o_grant_id=2; no further grant while busy is high.
2. All four channels valid continuously: grants occur in order 0,1,2,3,0. Each grant is preceded by a full busy high/low cycle, and each accepted word matches its channel's data.
3. i_chan_en=4'b1010 with all valid: only channels 1 and 3 are granted, alternating. Channels 0 and 2 never see ready.
4. i_dbg_busy tied 0 after a grant: o_timeout rises at T+1+64 clocks and the block returns to IDLE. The next grant goes to the next channel in rr order.
5. i_reset_n pulsed low during WAIT_DONE: o_dbg_valid/o_timeout/o_grant_id go to 0 immediately. There is no ready in the first clock after release, and the next grant goes to the lowest eligible channel (rr pointer at 0).
6. i_dbg_busy high at the moment a request arrives: no ready until busy has been low for one full IDLE cycle, then ready is asserted in that same cycle.
